// File: rtl/fft64_reorder_buf_pkg.sv
// Shared constants, read-pipeline tag type and the 6-bit bit-reversal helper
// for the 64-point FFT output reorder buffer.
package fft64_reorder_buf_pkg;

  localparam int NB        = 16;
  localparam int FRAME_LEN = 64;
  localparam int RAM_LAT   = 2;

  // Travels alongside each read address so the output stage knows bank and frame start
  typedef struct packed {
    logic valid;
    logic bank;
    logic first;
  } rd_tag_t;

  function automatic logic [5:0] bitrev6(input logic [5:0] a);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = a[5-i];
    return r;
  endfunction

endpackage

// File: rtl/fft64_reorder_buf_if.sv
// Sample stream into and out of the reorder buffer: enable, frame start,
// complex input and the bit-reversed complex output with its frame marker.
interface fft64_reorder_buf_if;
  import fft64_reorder_buf_pkg::*;

  logic          ed;
  logic          start;
  logic [NB-1:0] dr;
  logic [NB-1:0] di;
  logic          rdy;
  logic [NB-1:0] dor;
  logic [NB-1:0] doi;

  modport master (output ed, start, dr, di, input rdy, dor, doi);
  modport slave  (input ed, start, dr, di, output rdy, dor, doi);

endinterface

// File: rtl/fft64_reorder_buf_ram64.sv
// 64-word single-port RAM with a two-stage registered read; every register and
// the array itself hold while ed_i is low.
module fft64_reorder_buf_ram64
  import fft64_reorder_buf_pkg::*;
(
  input  logic          clk_i,
  input  logic          ed_i,
  input  logic          we_i,
  input  logic [5:0]    addr_i,
  input  logic [NB-1:0] din_i,
  output logic [NB-1:0] dout_o
);

  logic [NB-1:0] mem [FRAME_LEN];
  logic [NB-1:0] rd_q;
  logic [NB-1:0] dout_q;

  always_ff @(posedge clk_i) begin
    if (ed_i) begin
      if (we_i) mem[addr_i] <= din_i;
      rd_q   <= mem[addr_i];
      dout_q <= rd_q;
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/fft64_reorder_buf.sv
// Ping-pong reorder buffer: fills one bank in natural order while the other
// bank is read back in bit-reversed order, giving a gap-free output stream.
module fft64_reorder_buf
  import fft64_reorder_buf_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  fft64_reorder_buf_if.slave  bus
);

  logic [5:0]    wcnt_q, wcnt_d;
  logic [5:0]    rcnt_q, rcnt_d;
  logic          wr_act_q, wr_act_d;
  logic          wbank_q, wbank_d;
  logic          rd_act_q, rd_act_d;
  logic          vld_q, vld_d;
  logic          rdy_q, rdy_d;
  logic [NB-1:0] dor_q, dor_d;
  logic [NB-1:0] doi_q, doi_d;
  rd_tag_t [RAM_LAT-1:0] dl_q, dl_d;

  logic [NB-1:0] ram_dout [4];
  logic [1:0]    we_bank;
  logic [5:0]    waddr;
  logic [5:0]    raddr;
  rd_tag_t       out_tag;

  // The START cycle already writes sample 0, before wr_act_q has risen
  assign we_bank[0] = bus.ed & (bus.start | wr_act_q) & ~wbank_q;
  assign we_bank[1] = bus.ed & (bus.start | wr_act_q) &  wbank_q;
  assign waddr      = bus.start ? 6'd0 : wcnt_q;
  assign raddr      = bitrev6(rcnt_q);
  assign out_tag    = dl_q[RAM_LAT-1];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ram
      localparam int BANK = gi / 2;
      localparam int IMAG = gi % 2;
      fft64_reorder_buf_ram64 u_ram (
        .clk_i  (clk_i),
        .ed_i   (bus.ed),
        .we_i   (we_bank[BANK]),
        .addr_i (we_bank[BANK] ? waddr : raddr),
        .din_i  ((IMAG == 1) ? bus.di : bus.dr),
        .dout_o (ram_dout[gi])
      );
    end
  endgenerate

  always_comb begin
    wcnt_d   = wcnt_q;
    rcnt_d   = rcnt_q;
    wr_act_d = wr_act_q;
    wbank_d  = wbank_q;
    rd_act_d = rd_act_q;
    vld_d    = vld_q;
    rdy_d    = rdy_q;
    dor_d    = dor_q;
    doi_d    = doi_q;
    dl_d     = dl_q;
    if (bus.ed) begin
      if (bus.start) begin
        wr_act_d = 1'b1;
        wcnt_d   = 6'd1;
        rd_act_d = 1'b0;
        vld_d    = 1'b0;
        rdy_d    = 1'b0;
        dl_d     = '0;
      end else begin
        vld_d = out_tag.valid;
        rdy_d = out_tag.valid & out_tag.first;
        dor_d = out_tag.bank ? ram_dout[2] : ram_dout[0];
        doi_d = out_tag.bank ? ram_dout[3] : ram_dout[1];
        dl_d[0].valid = rd_act_q;
        dl_d[0].bank  = ~wbank_q;
        dl_d[0].first = (rcnt_q == 6'd0);
        for (int i = 1; i < RAM_LAT; i++) dl_d[i] = dl_q[i-1];
        if (rd_act_q) rcnt_d = rcnt_q + 6'd1;
        if (wr_act_q) begin
          wcnt_d = wcnt_q + 6'd1;
          // A completed fill hands its bank to the reader and starts a read frame
          if (wcnt_q == 6'(FRAME_LEN - 1)) begin
            wbank_d  = ~wbank_q;
            rd_act_d = 1'b1;
            rcnt_d   = 6'd0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wcnt_q   <= '0;
      rcnt_q   <= '0;
      wr_act_q <= 1'b0;
      wbank_q  <= 1'b0;
      rd_act_q <= 1'b0;
      vld_q    <= 1'b0;
      rdy_q    <= 1'b0;
      dor_q    <= '0;
      doi_q    <= '0;
      dl_q     <= '0;
    end else begin
      wcnt_q   <= wcnt_d;
      rcnt_q   <= rcnt_d;
      wr_act_q <= wr_act_d;
      wbank_q  <= wbank_d;
      rd_act_q <= rd_act_d;
      vld_q    <= vld_d;
      rdy_q    <= rdy_d;
      dor_q    <= dor_d;
      doi_q    <= doi_d;
      dl_q     <= dl_d;
    end
  end

  assign bus.rdy = rdy_q;
  assign bus.dor = vld_q ? dor_q : '0;
  assign bus.doi = vld_q ? doi_q : '0;

endmodule

// File: tb/tb_fft64_reorder_buf.sv
// Scoreboard bench for fft64_reorder_buf: a frame-level reference model predicts
// the output after every clock edge and a separate monitor compares each cycle.
module tb_fft64_reorder_buf;
  import fft64_reorder_buf_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fft64_reorder_buf_if bus();

  fft64_reorder_buf dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rdy;
    logic [NB-1:0] dor;
    logic [NB-1:0] doi;
  } exp_t;

  exp_t              exp_q[$];
  exp_t              held;
  logic [2*NB-1:0]   samples[$];
  bit                started = 0;
  int                ncnt = 0;
  int                n_checks = 0;
  int                n_errors = 0;
  int                cyc = 0;

  function automatic int brev(input int p);
    int r = 0;
    for (int i = 0; i < 6; i++)
      if (((p >> i) & 1) == 1) r = r + (1 << (5 - i));
    return r;
  endfunction

  function automatic logic [NB-1:0] rnd();
    return NB'($urandom);
  endfunction

  // Output after edge n (n counted from START) is sample f*64+bitrev(p), with k=n-66
  task automatic model(input logic r, input logic e, input logic s,
                       input logic [NB-1:0] re, input logic [NB-1:0] im);
    int k;
    int f;
    int p;
    logic [2*NB-1:0] w;
    if (r) begin
      started  = 0;
      held.rdy = 1'b0;
      held.dor = '0;
      held.doi = '0;
    end else if (e) begin
      if (s) begin
        started = 1;
        ncnt    = 0;
        samples.delete();
        samples.push_back({re, im});
        held.rdy = 1'b0;
        held.dor = '0;
        held.doi = '0;
      end else if (started) begin
        ncnt++;
        samples.push_back({re, im});
        if (ncnt >= 66) begin
          k = ncnt - 66;
          f = k / 64;
          p = k % 64;
          w = samples[f * 64 + brev(p)];
          held.rdy = (p == 0);
          held.dor = w[2*NB-1:NB];
          held.doi = w[NB-1:0];
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic s,
                      input logic [NB-1:0] re, input logic [NB-1:0] im);
    @(negedge clk);
    rst       = r;
    bus.ed    = e;
    bus.start = s;
    bus.dr    = re;
    bus.di    = im;
    @(posedge clk);
    #1;
    model(r, e, s, re, im);
    exp_q.push_back(held);
  endtask

  task automatic frame(input int base);
    step(1'b0, 1'b1, 1'b1, NB'(base), NB'(-base));
    for (int n = 1; n < 64; n++) step(1'b0, 1'b1, 1'b0, NB'(base + n), NB'(-(base + n)));
  endtask

  task automatic run_random(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b1, 1'b0, rnd(), rnd());
  endtask

  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        n_checks++;
        if (bus.rdy !== x.rdy || bus.dor !== x.dor || bus.doi !== x.doi) begin
          n_errors++;
          $display("FAIL out cyc=%0d got rdy=%0b dor=%0h doi=%0h expected rdy=%0b dor=%0h doi=%0h",
                   cyc, bus.rdy, bus.dor, bus.doi, x.rdy, x.dor, x.doi);
        end else if (x.rdy) begin
          $display("frame out cyc=%0d first dor=%0h doi=%0h", cyc, bus.dor, bus.doi);
        end
      end
    end
  end

  initial begin
    int k;
    held.rdy  = 1'b0;
    held.dor  = '0;
    held.doi  = '0;
    bus.ed    = 1'b1;
    bus.start = 1'b0;
    bus.dr    = '0;
    bus.di    = '0;

    // reset, then idle with no START: no RDY may appear
    repeat (2) step(1'b1, 1'b1, 1'b0, '0, '0);
    run_random(200);

    // single frame DR=n, DI=-n
    frame(0);
    run_random(140);
    repeat (2) step(1'b1, 1'b1, 1'b0, '0, '0);

    // back-to-back frames A then B, then continuous data
    frame(0);
    for (int n = 0; n < 64; n++) step(1'b0, 1'b1, 1'b0, NB'(100 + n), NB'(-(100 + n)));
    run_random(140);
    repeat (2) step(1'b1, 1'b1, 1'b0, '0, '0);

    // ED pattern 1,0,0,1 with junk data and START toggling on ED=0 cycles
    k = 0;
    for (int c = 0; c < 440; c++) begin
      if (c % 4 == 0 || c % 4 == 3) begin
        if (k < 64) step(1'b0, 1'b1, (k == 0), NB'(k), NB'(-k));
        else step(1'b0, 1'b1, 1'b0, rnd(), rnd());
        k++;
      end else begin
        step(1'b0, 1'b0, 1'($urandom_range(0, 1)), rnd(), rnd());
      end
    end

    // START mid-frame: 20 samples abandoned, then a full frame
    step(1'b0, 1'b1, 1'b1, NB'(500), NB'(600));
    for (int n = 1; n < 20; n++) step(1'b0, 1'b1, 1'b0, NB'(500 + n), NB'(600 + n));
    frame(0);
    run_random(140);

    // START exactly on the write wrap edge wins over the bank swap
    step(1'b0, 1'b1, 1'b1, NB'(700), NB'(800));
    for (int n = 1; n < 63; n++) step(1'b0, 1'b1, 1'b0, NB'(700 + n), NB'(800 + n));
    frame(300);
    run_random(140);

    // RST while output position 10 is on the bus
    frame(0);
    run_random(13);
    step(1'b1, 1'b1, 1'b0, '0, '0);
    run_random(100);
    frame(50);
    run_random(140);

    // random ED and occasional START
    for (int i = 0; i < 800; i++)
      step(1'b0, ($urandom_range(0, 9) < 8), ($urandom_range(0, 199) == 0), rnd(), rnd());

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fft64_reorder_buf.md
# fft64_reorder_buf

Ping-pong reorder buffer on the output side of the 64-point FFT datapath. Accepts a stream of complex samples in natural order, buffers each 64-sample frame in one bank of single-port RAM64 memories, and reads it back in 6-bit bit-reversed address order while the next frame fills the other bank. It writes to and reads from the RAM64 storage, and it compensates for the RAM64 two-cycle read latency so that the output stream is continuous.

## Interface
- nb, default from `USFFT64paramnb` (fft64_config.inc), width of each real and imaginary component
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- ED  in  1  enable; when 0, every register and both RAM banks hold
- START  in  1  frame start; sampled only when ED=1; input sample 0 arrives in the same cycle
- DR  in  nb  input real part
- DI  in  nb  input imaginary part
- RDY  out  1  one ED-cycle pulse, coincident with output position 0 of each frame
- DOR  out  nb  output real part, bit-reversed order
- DOI  out  nb  output imaginary part, bit-reversed order

## Operation
- State: wcnt[5:0] (write address), wbank (bank being written), rd_act (a read frame is in progress), rcnt[5:0] (read position), a 2-stage delay line for the read bank select and the read-valid flag, and vld (output-valid flag).
- RST=1 clears wcnt, rcnt, wbank, rd_act, vld, RDY and the delay line. DOR=DOI=0. RST takes priority over START and ED. RAM contents are not cleared.
- START with ED=1 sets wcnt to 1, writes the current sample to address 0 of the current wbank, and clears rd_act, vld and the delay line. It aborts any partial or in-progress frame.
- While writing, each ED cycle writes {DR,DI} to wbank at address wcnt, then increments wcnt modulo 64.
- When wcnt wraps from 63 to 0: toggle wbank, set rd_act=1, set rcnt=0.
- While reading, the read address into bank !wbank is bitrev(rcnt) = {rcnt[0],rcnt[1],…,rcnt[5]}. rcnt increments each ED cycle modulo 64.
- Read and write always target opposite banks, so RAM64 never sees a simultaneous read and write.
- Output mux: select the bank given by the bank-select line delayed by 2 ED cycles.
- DOR/DOI = mux output when vld=1, otherwise 0.
- vld is set with the first delayed read-valid and stays 1 while frames continue back to back.
- Frames arrive with no gaps between them. Output is likewise gap-free from the first RDY onward.
- The block has no back-pressure. The upstream source must supply a sample on every ED cycle after START.

## Timing
- Latency is counted in ED-qualified edges. Input sample n is captured on edge n, where edge 0 is the START edge.
- Read of a frame issues its addresses on edges 64…127.
- Output position k holds x[bitrev(k)] and is valid after edge 66+k.
- RDY is high for exactly the ED cycle that follows edge 66, then for the cycle after edge 130, and so on, once per 64 ED cycles.
- Frame-to-frame output latency is fixed at 66 ED cycles.
- While ED=0, outputs and RDY hold their values. If RDY was 1, it stays 1 until the next ED edge.
- Boundary: START on the same edge as the wcnt 63→0 wrap. START wins: no read frame begins and no swap occurs.

## Structure
- fft64_config.inc provides nb plus two new defines: frame length 64 and RAM latency 2. It also provides the bitrev6 function, which is shared with the FFT address generators.
- Submodule: RAM64, four instances (bank0 real/imag, bank1 real/imag). WE is driven per bank and ED is passed through.
- The control counters, delay line and output mux stay in this module.

## Test plan
- Reset: assert RST for 2 cycles with ED=1. Required: RDY=0, DOR=DOI=0, and no RDY pulse for 200 cycles without START.
- Single frame: START, then DR=n, DI=−n for n=0..63, ED=1 throughout. Required: RDY after edge 66. DOR reads 0,32,16,48,8,40,24,56,… and DOI is the negation of each value.
- Back-to-back frames: frame A is DR=n, frame B is DR=100+n, then continuous data. Required: RDY pulses after edges 66 and 130, and the output of B follows A with no gap (first value of B is 100).
- ED gaps: the single-frame stimulus with ED pattern 1,0,0,1 repeating. Required: the same output sequence in ED-qualified terms, and outputs held stable during ED=0 cycles.
- START mid-frame: START, 20 samples, then START again followed by a full frame. Required: the first RDY arrives 66 ED edges after the second START, and no data from the first 20 samples ever appears on the output.
- RST mid-readout: assert RST at output position 10. Required: DOR=DOI=0 and RDY=0 from the next cycle, with no output until a new START plus 66 cycles.
